fifo_flit_tx: RTL and testbench
===============================

FIFO_FLIT_TX -- requirements
Module: fifo_flit_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 32, flit width; flit type = bits [DATA_WIDTH-1:DATA_WIDTH-2].
REQ-002 Flit type encoding SHALL be 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 head+tail (single-flit packet).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 fifo_empty  in  1  source FIFO empty flag.
REQ-006 fifo_rd_en  out  1  pop strobe to source FIFO, combinational.
REQ-007 fifo_dout  in  DATA_WIDTH  source FIFO head entry, combinational-read, valid when fifo_empty=0.
REQ-008 out_valid  out  1  link flit valid.
REQ-009 out_ready  in  1  link sink ready.
REQ-010 out_data  out  DATA_WIDTH  link flit, registered.
REQ-011 in_packet  out  1  high while a packet is open (head sent, tail not yet sent).
REQ-012 proto_err  out  1  sticky framing-error flag.
REQ-013 pkt_count  out  16  count of tails/single-flit packets accepted by the link.

Function
REQ-014 Output stage SHALL be a single register (out_valid/out_data); free = ~out_valid | out_ready.
REQ-015 fifo_rd_en SHALL equal ~fifo_empty & free; never asserted when fifo_empty=1.
REQ-016 Popped flit, if forwarded, SHALL appear on out_data with out_valid=1 the next cycle (latency 1).
REQ-017 out_data SHALL hold stable while out_valid & ~out_ready; out_valid cleared after handshake when nothing new is forwarded.
REQ-018 Back-to-back throughput SHALL be one flit/cycle while out_ready=1 and fifo_empty=0.
REQ-019 FSM states IDLE and IN_PKT; in_packet=1 exactly in IN_PKT.
REQ-020 IDLE: head -> forward, go IN_PKT; head+tail -> forward, stay IDLE; body or tail -> pop, drop, set proto_err.
REQ-021 IN_PKT: body -> forward, stay; tail -> forward, go IDLE; head or head+tail -> pop, drop, set proto_err, stay IN_PKT.
REQ-022 Dropped flits SHALL consume the pop cycle but SHALL NOT assert out_valid.
REQ-023 FSM transitions SHALL occur on the pop cycle, not the link handshake.
REQ-024 pkt_count SHALL increment by 1 on each out_valid & out_ready cycle whose flit type is tail or head+tail; wraps 16'hFFFF -> 0.
REQ-025 proto_err SHALL stay 1 until reset.

Reset
REQ-026 rst=0 SHALL immediately force out_valid=0, out_data=0, state IDLE, in_packet=0, proto_err=0, pkt_count=0.
REQ-027 fifo_rd_en SHALL be 0 while rst=0; a packet open at reset is abandoned with no error flagged.
REQ-028 First pop SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro FIFO_FLIT_TX_PKT_COUNT_EN: defined -> pkt_count per REQ-024.
REQ-030 Without FIFO_FLIT_TX_PKT_COUNT_EN: counter logic omitted, port retained, tied to 0; all other behaviour unchanged.

Verification
REQ-031 FIFO holds head 0x4000_0001, body 0x0000_0002, tail 0x8000_0003, out_ready=1 -> three consecutive pops, flits on out_data cycles 1-3, in_packet 1 for cycles 1-2, pkt_count=1.
REQ-032 Same packet, out_ready=0 for 4 cycles after first flit -> out_data holds 0x4000_0001, fifo_rd_en=0, no loss/duplication after out_ready=1.
REQ-033 Body 0x0000_0005 while IDLE -> popped, out_valid stays 0, proto_err=1 until reset.
REQ-034 Head then second head 0x4000_0009 -> second dropped, proto_err=1, in_packet stays 1, following tail closes packet.
REQ-035 65536 head+tail flits (0xC000_0000) -> pkt_count wraps to 0; with macro undefined pkt_count stays 0 throughout.
REQ-036 rst low mid-packet with out_valid=1 -> out_valid, in_packet, proto_err, pkt_count=0 immediately, before next clock edge.

Source files
------------

// File: rtl/fifo_flit_tx_if.sv
// Source-FIFO and link handshake signals of the flit transmitter.
// slave = transmitter side, master = environment side (FIFO + link sink).
interface fifo_flit_tx_if #(parameter int DATA_WIDTH = 32);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport slave  (input  fifo_empty, fifo_dout, out_ready,
                  output fifo_rd_en, out_valid, out_data);
  modport master (output fifo_empty, fifo_dout, out_ready,
                  input  fifo_rd_en, out_valid, out_data);
endinterface

// File: rtl/fifo_flit_tx.sv
// Flit transmitter: pops a source FIFO, checks head/body/tail framing and drives a
// single-register link stage. Define FIFO_FLIT_TX_PKT_COUNT_EN to build the packet counter.
module fifo_flit_tx #(
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  fifo_flit_tx_if.slave  bus,
  output logic           in_packet,
  output logic           proto_err,
  output logic [15:0]    pkt_count
);

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t                state_q, state_d;
  logic                  vld_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;
  logic                  free, rd_en, fwd, err_set;
  logic [1:0]            ftype;

  assign ftype = bus.fifo_dout[DATA_WIDTH-1:DATA_WIDTH-2];
  assign free  = ~vld_q | bus.out_ready;
  // rst gates the pop so nothing is consumed while held in reset
  assign rd_en = rst & ~bus.fifo_empty & free;

  always_comb begin
    state_d = state_q;
    fwd     = 1'b0;
    err_set = 1'b0;
    if (rd_en) begin
      unique case (state_q)
        IDLE: begin
          unique case (ftype)
            T_HEAD:  begin fwd = 1'b1; state_d = IN_PKT; end
            T_HT:    fwd = 1'b1;
            default: err_set = 1'b1;
          endcase
        end
        IN_PKT: begin
          unique case (ftype)
            T_BODY:  fwd = 1'b1;
            T_TAIL:  begin fwd = 1'b1; state_d = IDLE; end
            default: err_set = 1'b1;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (err_set) err_q <= 1'b1;
      if (fwd) begin
        vld_q  <= 1'b1;
        data_q <= bus.fifo_dout;
      end else if (bus.out_ready) begin
        vld_q  <= 1'b0;
      end
    end
  end

`ifdef FIFO_FLIT_TX_PKT_COUNT_EN
  logic [15:0] cnt_q;
  // tail and head+tail both carry a 1 in the top type bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         cnt_q <= '0;
    else if (vld_q & bus.out_ready & data_q[DATA_WIDTH-1]) cnt_q <= cnt_q + 16'd1;
  end
  assign pkt_count = cnt_q;
`else
  assign pkt_count = 16'd0;
`endif

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = vld_q;
  assign bus.out_data   = data_q;
  assign in_packet      = (state_q == IN_PKT);
  assign proto_err      = err_q;

endmodule

// File: tb/tb_fifo_flit_tx.sv
// Directed table-driven bench for fifo_flit_tx plus reset and counter-wrap sequences.
module tb_fifo_flit_tx;

`ifdef FIFO_FLIT_TX_PKT_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_packet, proto_err;
  logic [15:0] pkt_count;
  int          n_chk  = 0;
  int          n_fail = 0;

  fifo_flit_tx_if #(.DATA_WIDTH(32)) bus ();

  fifo_flit_tx #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .in_packet (in_packet),
    .proto_err (proto_err),
    .pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        empty;
    logic [31:0] dout;
    logic        ready;
    logic        rd_en;
    logic        valid;
    logic [31:0] data;
    logic        in_pkt;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  vec_t tv[18];

  function automatic vec_t mk(logic e, logic [31:0] d, logic r, logic rd, logic v,
                              logic [31:0] od, logic ip, logic er, logic [15:0] c);
    vec_t t;
    t.empty = e; t.dout = d; t.ready = r; t.rd_en = rd; t.valid = v;
    t.data = od; t.in_pkt = ip; t.err = er; t.cnt = CNT_EN ? c : 16'd0;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic e, input logic [31:0] d, input logic r);
    bus.fifo_empty = e;
    bus.fifo_dout  = d;
    bus.out_ready  = r;
  endtask

  task automatic check_outs(input string tag, input logic v, input logic [31:0] d,
                            input logic ip, input logic er, input logic [15:0] c);
    chk({tag, " out_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    chk({tag, " out_data"},  bus.out_data, d);
    chk({tag, " in_packet"}, {31'd0, in_packet}, {31'd0, ip});
    chk({tag, " proto_err"}, {31'd0, proto_err}, {31'd0, er});
    chk({tag, " pkt_count"}, {16'd0, pkt_count}, {16'd0, c});
  endtask

  initial begin
    int stalls;
    // REQ-031 packet, REQ-032 backpressure, REQ-033 stray body, REQ-034 double head
    tv[0]  = mk(0, 32'h4000_0001, 1, 1, 1, 32'h4000_0001, 1, 0, 0);
    tv[1]  = mk(0, 32'h0000_0002, 1, 1, 1, 32'h0000_0002, 1, 0, 0);
    tv[2]  = mk(0, 32'h8000_0003, 1, 1, 1, 32'h8000_0003, 0, 0, 0);
    tv[3]  = mk(1, 32'h0000_0000, 1, 0, 0, 32'h8000_0003, 0, 0, 1);
    tv[4]  = mk(0, 32'h4000_0001, 1, 1, 1, 32'h4000_0001, 1, 0, 1);
    tv[5]  = mk(0, 32'h0000_0002, 0, 0, 1, 32'h4000_0001, 1, 0, 1);
    tv[6]  = mk(0, 32'h0000_0002, 0, 0, 1, 32'h4000_0001, 1, 0, 1);
    tv[7]  = mk(0, 32'h0000_0002, 0, 0, 1, 32'h4000_0001, 1, 0, 1);
    tv[8]  = mk(0, 32'h0000_0002, 0, 0, 1, 32'h4000_0001, 1, 0, 1);
    tv[9]  = mk(0, 32'h0000_0002, 1, 1, 1, 32'h0000_0002, 1, 0, 1);
    tv[10] = mk(0, 32'h8000_0003, 1, 1, 1, 32'h8000_0003, 0, 0, 1);
    tv[11] = mk(1, 32'h0000_0000, 1, 0, 0, 32'h8000_0003, 0, 0, 2);
    tv[12] = mk(0, 32'h0000_0005, 1, 1, 0, 32'h8000_0003, 0, 1, 2);
    tv[13] = mk(1, 32'h0000_0000, 1, 0, 0, 32'h8000_0003, 0, 1, 2);
    tv[14] = mk(0, 32'h4000_0001, 1, 1, 1, 32'h4000_0001, 1, 1, 2);
    tv[15] = mk(0, 32'h4000_0009, 1, 1, 0, 32'h4000_0001, 1, 1, 2);
    tv[16] = mk(0, 32'h8000_0003, 1, 1, 1, 32'h8000_0003, 0, 1, 2);
    tv[17] = mk(1, 32'h0000_0000, 1, 0, 0, 32'h8000_0003, 0, 1, 3);

    // reset state, with a non-empty FIFO to show the pop is held off
    rst = 1'b0;
    drive(0, 32'h4000_0001, 1);
    #1;
    chk("reset rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    check_outs("reset", 0, 32'd0, 0, 0, 16'd0);
    drive(1, 32'd0, 1);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(tv[i].empty, tv[i].dout, tv[i].ready);
      #1;
      chk($sformatf("v%0d rd_en", i), {31'd0, bus.fifo_rd_en}, {31'd0, tv[i].rd_en});
      @(posedge clk);
      #1;
      check_outs($sformatf("v%0d", i), tv[i].valid, tv[i].data, tv[i].in_pkt,
                 tv[i].err, tv[i].cnt);
      @(negedge clk);
    end

    // mid-packet reset with a stalled flit on the link
    drive(0, 32'h4000_0001, 0);
    @(posedge clk); #1;
    check_outs("pre-rst", 1, 32'h4000_0001, 1, 1, CNT_EN ? 16'd3 : 16'd0);
    @(negedge clk);
    drive(0, 32'h0000_0002, 1);
    #2 rst = 1'b0;
    #1;
    chk("async rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    check_outs("async rst", 0, 32'd0, 0, 0, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 32'h4000_0001, 1);
    #1;
    chk("first-pop rd_en", {31'd0, bus.fifo_rd_en}, 32'd1);
    @(posedge clk); #1;
    check_outs("first-pop", 1, 32'h4000_0001, 1, 0, 16'd0);

    // counter wrap with continuous single-flit packets
    @(negedge clk);
    rst = 1'b0;
    #1 rst = 1'b1;
    drive(0, 32'hC000_0000, 1);
    stalls = 0;
    for (int i = 0; i < 65536; i++) begin
      #1;
      if (bus.fifo_rd_en !== 1'b1) stalls++;
      @(posedge clk); #1;
      if (i == 0) chk("ht first in_packet", {31'd0, in_packet}, 32'd0);
      @(negedge clk);
    end
    chk("ht throughput stalls", stalls, 32'd0);
    chk("ht pkt_count ffff", {16'd0, pkt_count}, CNT_EN ? 32'h0000_FFFF : 32'd0);
    chk("ht proto_err", {31'd0, proto_err}, 32'd0);
    drive(1, 32'd0, 1);
    @(posedge clk); #1;
    chk("ht pkt_count wrap", {16'd0, pkt_count}, 32'd0);
    chk("ht valid drained", {31'd0, bus.out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
